// File: rtl/lfsr_sampler.sv
// Samples an LFSR word every clock while running, buffers the samples in a FWFT FIFO,
// and measures the sequence period, dropped samples and all-zero lock-up.
module lfsr_sampler #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [N-1:0]     lfsr_q,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             running,
  output logic             period_found,
  output logic [CNT_W-1:0] period_len,
  output logic             lockup,
  output logic [15:0]      drop_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [N-1:0]  start_word;
  logic          prev_zero;

  logic take, match, lock, full, empty, push, pop, drop;

  assign running   = (state_q == RUN);
  // A start pulse in RUN restarts the run; that edge only clears, it takes no sample.
  assign take      = running && !start;
  assign match     = take && (sample_cnt != '0) && (lfsr_q == start_word);
  assign lock      = take && (lfsr_q == '0) && prev_zero;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push      = take && (!full || pop);
  assign drop      = take && full && !pop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (start)                       state_d = RUN;
        else if (stop || match || lock)  state_d = DONE;
      end
      DONE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      start_word   <= '0;
      prev_zero    <= 1'b0;
      period_found <= 1'b0;
      period_len   <= '0;
      lockup       <= 1'b0;
      drop_cnt     <= '0;
      sample_cnt   <= '0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (start) begin
        sample_cnt   <= '0;
        period_found <= 1'b0;
        period_len   <= '0;
        lockup       <= 1'b0;
        drop_cnt     <= '0;
        prev_zero    <= 1'b0;
      end else if (take) begin
        if (sample_cnt == '0) start_word <= lfsr_q;
        if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
        prev_zero <= (lfsr_q == '0);
        if (match) begin
          period_found <= 1'b1;
          period_len   <= sample_cnt;
        end
        if (lock) lockup <= 1'b1;
        if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; out_data is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lfsr_q;
  end

endmodule

// File: tb/tb_lfsr_sampler.sv
// Directed bench for lfsr_sampler (N=4, DEPTH=8): reset, period, overflow, full+pop,
// lock-up and restart/stop scenarios with hand-computed expectations.
module tb_lfsr_sampler;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, start, stop, out_ready;
  logic [N-1:0]     lfsr_q;
  logic [N-1:0]     out_data;
  logic             out_valid, running, period_found, lockup;
  logic [CNT_W-1:0] period_len, sample_cnt;
  logic [15:0]      drop_cnt;

  int errors = 0;
  int checks = 0;

  lfsr_sampler #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .lfsr_q(lfsr_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .running(running), .period_found(period_found), .period_len(period_len),
    .lockup(lockup), .drop_cnt(drop_cnt), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " out_valid"},    32'(out_valid),    32'd0);
    check({tag, " running"},      32'(running),      32'd0);
    check({tag, " period_found"}, 32'(period_found), 32'd0);
    check({tag, " period_len"},   period_len,        32'd0);
    check({tag, " lockup"},       32'(lockup),       32'd0);
    check({tag, " drop_cnt"},     32'(drop_cnt),     32'd0);
    check({tag, " sample_cnt"},   sample_cnt,        32'd0);
    check({tag, " out_data"},     32'(out_data),     32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0; lfsr_q = '0;
    step(); step();
    reset = 1'b0;
    check_idle_zero("reset");

    // stop in IDLE is ignored
    stop = 1'b1; step(); stop = 1'b0;
    check("idle_stop running", 32'(running), 32'd0);
    check("idle_stop sample_cnt", sample_cnt, 32'd0);

    // Reset mid-run with 3 buffered words
    start = 1'b1; step(); start = 1'b0;
    check("run1 running", 32'(running), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      lfsr_q = 4'(i); step();
    end
    check("run1 sample_cnt", sample_cnt, 32'd3);
    check("run1 out_valid", 32'(out_valid), 32'd1);
    check("run1 out_data", 32'(out_data), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check_idle_zero("midrun_reset");

    // Period detection: 3..15,0,1,2,3
    out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      lfsr_q = 4'((3 + i) % 16); step();
      check("period out_valid", 32'(out_valid), 32'd1);
      check("period out_data", 32'(out_data), 32'((3 + i) % 16));
    end
    check("period period_found", 32'(period_found), 32'd1);
    check("period period_len", period_len, 32'd16);
    check("period running", 32'(running), 32'd0);
    check("period lockup", 32'(lockup), 32'd0);
    check("period sample_cnt", sample_cnt, 32'd17);
    lfsr_q = 4'd7; step();
    check("period drained", 32'(out_valid), 32'd0);
    check("period sample_cnt hold", sample_cnt, 32'd17);

    // Overflow: 12 samples into an 8-deep FIFO, stop with the 12th
    out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      lfsr_q = 4'(i + 1);
      stop = (i == 11);
      step();
    end
    stop = 1'b0;
    check("ovf running", 32'(running), 32'd0);
    check("ovf drop_cnt", 32'(drop_cnt), 32'd4);
    check("ovf sample_cnt", sample_cnt, 32'd12);
    check("ovf period_found", 32'(period_found), 32'd0);
    check("ovf out_data", 32'(out_data), 32'd1);
    step();
    check("ovf hold out_data", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("ovf drain valid", 32'(out_valid), 32'd1);
      check("ovf drain data", 32'(out_data), 32'(j + 1));
      step();
    end
    check("ovf empty", 32'(out_valid), 32'd0);

    // Full with simultaneous pop
    out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("fullpop drop_cnt cleared", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      lfsr_q = 4'(i + 1); step();
    end
    check("fullpop head", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lfsr_q = 4'(i + 9);
      stop = (i == 4);
      step();
      check("fullpop head", 32'(out_data), 32'(i + 2));
      check("fullpop drop_cnt", 32'(drop_cnt), 32'd0);
    end
    stop = 1'b0;
    check("fullpop running", 32'(running), 32'd0);
    for (int j = 0; j < 8; j++) begin
      check("fullpop drain valid", 32'(out_valid), 32'd1);
      check("fullpop drain data", 32'(out_data), 32'(j + 6));
      step();
    end
    check("fullpop empty", 32'(out_valid), 32'd0);

    // Lock-up: 5,0,0
    start = 1'b1; step(); start = 1'b0;
    lfsr_q = 4'd5; step();
    lfsr_q = 4'd0; step();
    check("lock single zero", 32'(lockup), 32'd0);
    check("lock still running", 32'(running), 32'd1);
    step();
    check("lock lockup", 32'(lockup), 32'd1);
    check("lock running", 32'(running), 32'd0);
    check("lock period_found", 32'(period_found), 32'd0);
    check("lock sample_cnt", sample_cnt, 32'd3);
    step();
    check("lock hold sample_cnt", sample_cnt, 32'd3);

    // Restart from DONE, 2 samples, stop with the second
    start = 1'b1; step(); start = 1'b0;
    check("restart lockup cleared", 32'(lockup), 32'd0);
    check("restart sample_cnt cleared", sample_cnt, 32'd0);
    check("restart running", 32'(running), 32'd1);
    lfsr_q = 4'd9; step();
    lfsr_q = 4'd10; stop = 1'b1; step(); stop = 1'b0;
    check("restart sample_cnt", sample_cnt, 32'd2);
    check("restart stopped", 32'(running), 32'd0);
    stop = 1'b1; step(); stop = 1'b0;
    check("done_stop running", 32'(running), 32'd0);
    check("done_stop sample_cnt", sample_cnt, 32'd2);

    // start while in RUN restarts the run
    start = 1'b1; step(); start = 1'b0;
    lfsr_q = 4'd4; step();
    lfsr_q = 4'd5; step();
    check("rerun sample_cnt", sample_cnt, 32'd2);
    start = 1'b1; step(); start = 1'b0;
    check("rerun cleared", sample_cnt, 32'd0);
    check("rerun running", 32'(running), 32'd1);
    lfsr_q = 4'd6; step();
    check("rerun first sample", sample_cnt, 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    check("rerun stopped", 32'(running), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_sampler.md
Name: lfsr_sampler

Overview:
- Sits directly downstream of the lfsr PRNG stage. Samples the N-bit LFSR word every clock while running.
- Buffers samples in a small FIFO and presents them on a valid/ready output to the display/UART consumer.
- Measures the sequence period, counts samples dropped on a full FIFO, and detects the all-zero lock-up state. Lets the board confirm a full period without simulator waits.

Parameters:
- N, 32, LFSR word width (bits).
- DEPTH, 8, FIFO depth in words; power of two, ≥2.
- CNT_W, 32, width of the sample and period counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a measurement run.
- stop  in  1  one-cycle pulse: end the run early.
- lfsr_q  in  N  current LFSR output word.
- out_data  out  N  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- running  out  1  FSM in RUN.
- period_found  out  1  sticky: start word seen again.
- period_len  out  CNT_W  samples between the two occurrences of the start word.
- lockup  out  1  sticky: two consecutive all-zero samples.
- drop_cnt  out  16  saturating count of samples lost to a full FIFO.
- sample_cnt  out  CNT_W  samples taken in the current run.

Behaviour:
- Reset (reset=1 at an edge): FSM=IDLE; FIFO empty. All outputs are 0: out_valid, running, period_found, period_len, lockup, drop_cnt, sample_cnt. out_data=0. Reset overrides everything else in the same cycle, including mid-run.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE on stop, on period match, or on lockup.
  - DONE→RUN on start.
  - start while in RUN restarts the run (same clears as below).
  - stop in IDLE/DONE is ignored.
- Entering RUN (the edge where start=1) clears sample_cnt, period_found, period_len, lockup and drop_cnt. The FIFO is not cleared.
- Sampling: at each rising edge with FSM=RUN, lfsr_q is one sample. The first sample of a run has index 0 and is captured as start_word; sample_cnt increments per sample.
- Period match: a sample with index k≥1 where lfsr_q==start_word sets period_found=1, period_len=k, and moves FSM→DONE. That sample is still pushed.
- Lockup: a sample equal to 0 whose previous sample in the same run was also 0 sets lockup=1 and moves FSM→DONE. That sample is still pushed. A single zero is not a lockup.
- Both match and lockup on the same sample: both flags set; FSM→DONE.
- stop and a sample in the same cycle: the sample is taken; FSM→DONE.
- FIFO:
  - First-word-fall-through. out_data = head; out_valid = !empty.
  - Pop when out_valid && out_ready.
  - Push when a sample is taken and (not full, or a pop occurs in the same cycle). Full with a simultaneous pop: both happen; the count is unchanged.
  - Full with no pop: the sample is dropped; drop_cnt+1, saturating at 16'hFFFF.
  - Latency: a word pushed at edge t is visible on out_data/out_valid after edge t if the FIFO was empty.
  - Pointers wrap modulo DEPTH. Count range 0..DEPTH.
  - out_data holds its value while out_valid=1 and out_ready=0.
- Counters: sample_cnt and period_len saturate at all-ones and do not wrap.
- DONE: sampling stops; flags and counters hold; the FIFO keeps draining normally.

Test Plan:
- Reset mid-run: N=4, DEPTH=8, RUN with 3 words buffered, assert reset for one cycle → out_valid=0, running=0, sample_cnt=0, drop_cnt=0, all flags 0 on the next cycle.
- Period detection: N=4, out_ready=1; drive lfsr_q = 3,4,…,15,0,1,2,3 (incrementing mod 16); pulse start → period_found=1, period_len=16, running=0 after the 17th sample. The single 0 gives lockup=0. out_data sequence equals the input order.
- Overflow: DEPTH=8, out_ready=0, 12 distinct samples then stop → FIFO holds the first 8 words, drop_cnt=4, out_data = the first sample. Then out_ready=1 → 8 words drain in order, then out_valid=0.
- Full with simultaneous pop: FIFO full, out_ready=1, RUN continues for 5 cycles → drop_cnt=0, count stays 8, output order preserved.
- Lockup: drive lfsr_q = 5,0,0 → lockup=1, FSM=DONE after the third sample, period_found=0, sample_cnt=3.
- Restart/stop: in DONE pulse start, feed 2 samples, pulse stop → flags cleared at restart, sample_cnt=2, running=0. A stop pulse in IDLE leaves the state unchanged.
